// File: rtl/asg_sweep_ctrl.sv
// rtl/asg_sweep_ctrl.sv - frequency-sweep sequencer driving one ASG channel step word
// Walks the step word between start and stop, holding each point for a programmable dwell.
module asg_sweep_ctrl #(
  parameter int STW = 62
) (
  input  logic             dac_clk_i,
  input  logic             dac_rst_i,
  input  logic             cfg_start_i,
  input  logic             cfg_stop_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [STW-1:0]   cfg_step_start_i,
  input  logic [STW-1:0]   cfg_step_stop_i,
  input  logic [STW-1:0]   cfg_step_inc_i,
  input  logic [31:0]      cfg_dwell_i,
  input  logic [15:0]      cfg_nsweep_i,
  output logic [STW-1:0]   asg_step_o,
  output logic             asg_step_vld_o,
  output logic             asg_trig_o,
  output logic             asg_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             dir_o,
  output logic [15:0]      sweep_cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t         state_q;
  logic [STW-1:0] step_q, start_q, stop_q, inc_q;
  logic [31:0]    dwell_cfg_q, dwell_q;
  logic [15:0]    nsweep_q, cnt_q;
  logic [1:0]     mode_q;
  logic           vld_q, trig_q, asg_rst_q, busy_q, done_q, dir_q, err_q;

  logic [STW:0]   up_sum, dn_diff;
  logic [STW-1:0] up_next_d, dn_next_d;
  logic [15:0]    cnt_d;
  logic [31:0]    dwell_ld;
  logic           last_sweep, cfg_ok;

  // One extra bit catches adder carry / subtractor borrow so the step never wraps.
  always_comb begin
    up_sum    = {1'b0, step_q} + {1'b0, inc_q};
    dn_diff   = {1'b0, step_q} - {1'b0, inc_q};
    up_next_d = (up_sum[STW] || (up_sum[STW-1:0] > stop_q)) ? stop_q : up_sum[STW-1:0];
    dn_next_d = (dn_diff[STW] || (dn_diff[STW-1:0] < start_q)) ? start_q : dn_diff[STW-1:0];
    cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    last_sweep = (nsweep_q != 16'd0) && ((cnt_q + 16'd1) == nsweep_q);
    dwell_ld   = (dwell_cfg_q == 32'd0) ? 32'd1 : dwell_cfg_q;
    cfg_ok     = (cfg_step_start_i <= cfg_step_stop_i) && (cfg_step_inc_i != '0);
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      inc_q       <= '0;
      dwell_cfg_q <= '0;
      dwell_q     <= '0;
      nsweep_q    <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      vld_q       <= 1'b0;
      trig_q      <= 1'b0;
      asg_rst_q   <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      vld_q  <= 1'b0;
      trig_q <= 1'b0;
      err_q  <= 1'b0;
      if (cfg_stop_i) begin
        state_q   <= S_IDLE;
        asg_rst_q <= 1'b1;
        busy_q    <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (cfg_start_i) begin
              if (!cfg_ok) begin
                err_q <= 1'b1;
              end else begin
                mode_q      <= cfg_mode_i;
                start_q     <= cfg_step_start_i;
                stop_q      <= cfg_step_stop_i;
                inc_q       <= cfg_step_inc_i;
                dwell_cfg_q <= cfg_dwell_i;
                nsweep_q    <= cfg_nsweep_i;
                step_q      <= cfg_step_start_i;
                vld_q       <= 1'b1;
                asg_rst_q   <= 1'b0;
                dir_q       <= 1'b0;
                cnt_q       <= '0;
                done_q      <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= S_ARM;
              end
            end
          end
          S_ARM: begin
            trig_q  <= 1'b1;
            dwell_q <= dwell_ld;
            state_q <= S_RUN;
          end
          S_RUN: begin
            if (dwell_q > 32'd1) begin
              dwell_q <= dwell_q - 32'd1;
            end else begin
              dwell_q <= dwell_ld;
              if (!dir_q && (step_q != stop_q)) begin
                step_q <= up_next_d;
                vld_q  <= 1'b1;
              end else if (dir_q && (step_q != start_q)) begin
                step_q <= dn_next_d;
                vld_q  <= 1'b1;
              end else if (!dir_q && (mode_q == 2'd2) && (start_q != stop_q)) begin
                dir_q  <= 1'b1;
                step_q <= dn_next_d;
                vld_q  <= 1'b1;
              end else if ((mode_q == 2'd0) || (mode_q == 2'd3)) begin
                cnt_q   <= 16'd1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                // Sweep boundary in mode 1, or mode 2 end of the down-leg (or a degenerate up-leg).
                cnt_q <= cnt_d;
                if (last_sweep) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  dir_q  <= 1'b0;
                  step_q <= (mode_q == 2'd1) ? start_q : up_next_d;
                  vld_q  <= 1'b1;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign asg_step_o     = step_q;
  assign asg_step_vld_o = vld_q;
  assign asg_trig_o     = trig_q;
  assign asg_rst_o      = asg_rst_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign dir_o          = dir_q;
  assign sweep_cnt_o    = cnt_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_asg_sweep_ctrl.sv
// tb/tb_asg_sweep_ctrl.sv - directed self-checking bench for asg_sweep_ctrl
module tb_asg_sweep_ctrl;
  localparam int STW = 62;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_start_i = 1'b0, cfg_stop_i = 1'b0;
  logic [1:0]      cfg_mode_i = '0;
  logic [STW-1:0]  cfg_step_start_i = '0, cfg_step_stop_i = '0, cfg_step_inc_i = '0;
  logic [31:0]     cfg_dwell_i = '0;
  logic [15:0]     cfg_nsweep_i = '0;
  logic [STW-1:0]  asg_step_o;
  logic            asg_step_vld_o, asg_trig_o, asg_rst_o, busy_o, done_o, dir_o, err_o;
  logic [15:0]     sweep_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [STW-1:0] pt_step [16];
  int             pt_cyc  [16];
  logic           pt_dir  [16];
  int             n_pts, trig_cnt, trig_cyc, done_cyc, cyc;

  asg_sweep_ctrl #(.STW(STW)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst),
    .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_mode_i(cfg_mode_i),
    .cfg_step_start_i(cfg_step_start_i), .cfg_step_stop_i(cfg_step_stop_i),
    .cfg_step_inc_i(cfg_step_inc_i), .cfg_dwell_i(cfg_dwell_i), .cfg_nsweep_i(cfg_nsweep_i),
    .asg_step_o(asg_step_o), .asg_step_vld_o(asg_step_vld_o), .asg_trig_o(asg_trig_o),
    .asg_rst_o(asg_rst_o), .busy_o(busy_o), .done_o(done_o), .dir_o(dir_o),
    .sweep_cnt_o(sweep_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [STW-1:0] s, input logic [STW-1:0] e,
                         input logic [STW-1:0] inc, input logic [31:0] d, input logic [15:0] n);
    cfg_mode_i = m; cfg_step_start_i = s; cfg_step_stop_i = e;
    cfg_step_inc_i = inc; cfg_dwell_i = d; cfg_nsweep_i = n;
  endtask

  task automatic pulse_start();
    cfg_start_i = 1'b1;
    tick();
    cfg_start_i = 1'b0;
  endtask

  task automatic record();
    if (n_pts < 16) begin
      pt_step[n_pts] = asg_step_o;
      pt_cyc[n_pts]  = cyc;
      pt_dir[n_pts]  = dir_o;
    end
    n_pts++;
  endtask

  // Cycle 0 is the sample just after the accepting edge E0; E1 is cycle 1.
  task automatic collect(input int max_cyc);
    for (int i = 0; i < 16; i++) begin pt_step[i] = '1; pt_cyc[i] = -1; pt_dir[i] = 1'bx; end
    n_pts = 0; trig_cnt = 0; trig_cyc = -1; cyc = 0;
    if (asg_step_vld_o) record();
    while (!done_o && cyc < max_cyc) begin
      tick();
      cyc++;
      if (asg_step_vld_o) record();
      if (asg_trig_o) begin trig_cnt++; trig_cyc = cyc; end
    end
    done_cyc = done_o ? cyc : -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({asg_step_o, asg_step_vld_o, asg_trig_o, asg_rst_o, busy_o, done_o, dir_o, sweep_cnt_o, err_o}
        !== {{STW{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: step=%0d vld=%b trig=%b rst=%b busy=%b done=%b dir=%b cnt=%0d err=%b",
               asg_step_o, asg_step_vld_o, asg_trig_o, asg_rst_o, busy_o, done_o, dir_o, sweep_cnt_o, err_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reject();
    set_cfg(2'd0, 62'd50, 62'd40, 62'd10, 32'd4, 16'd0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) set_cfg(2'd0, 62'd10, 62'd40, 62'd0, 32'd4, 16'd0);
      pulse_start();
      n_checks++;
      if ({err_o, busy_o, asg_rst_o, asg_step_vld_o} !== 4'b1010) begin
        n_fail++;
        $display("FAIL reject_%0d: err=%b busy=%b asg_rst=%b vld=%b, want 1 0 1 0", k, err_o, busy_o, asg_rst_o, asg_step_vld_o);
      end
      tick();
      n_checks++;
      if ({err_o, busy_o, asg_rst_o} !== 3'b001) begin
        n_fail++;
        $display("FAIL reject_after_%0d: err=%b busy=%b asg_rst=%b, want 0 0 1", k, err_o, busy_o, asg_rst_o);
      end
    end
  endtask

  task automatic test_start_stop_same();
    set_cfg(2'd0, 62'd0, 62'd10, 62'd5, 32'd2, 16'd0);
    cfg_start_i = 1'b1; cfg_stop_i = 1'b1;
    tick();
    cfg_start_i = 1'b0; cfg_stop_i = 1'b0;
    n_checks++;
    if ({busy_o, asg_step_vld_o, err_o, asg_rst_o} !== 4'b0001) begin
      n_fail++;
      $display("FAIL start_stop_same: busy=%b vld=%b err=%b asg_rst=%b, want 0 0 0 1", busy_o, asg_step_vld_o, err_o, asg_rst_o);
    end
  endtask

  task automatic test_mode0_basic();
    logic [STW-1:0] es [4] = '{62'd100, 62'd110, 62'd120, 62'd130};
    int             ec [4] = '{0, 5, 9, 13};
    set_cfg(2'd0, 62'd100, 62'd130, 62'd10, 32'd4, 16'd0);
    pulse_start();
    n_checks++;
    if ({busy_o, asg_rst_o, sweep_cnt_o} !== {1'b1, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL m0_arm: busy=%b asg_rst=%b cnt=%0d, want 1 0 0", busy_o, asg_rst_o, sweep_cnt_o);
    end
    collect(100);
    n_checks++;
    if (n_pts !== 4 || done_cyc !== 17 || trig_cnt !== 1 || trig_cyc !== 1) begin
      n_fail++;
      $display("FAIL m0_timing: pts=%0d done_cyc=%0d trig=%0d@%0d, want 4 17 1@1", n_pts, done_cyc, trig_cnt, trig_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (pt_step[i] !== es[i] || pt_cyc[i] !== ec[i]) begin
        n_fail++;
        $display("FAIL m0_point%0d: step=%0d@%0d, want %0d@%0d", i, pt_step[i], pt_cyc[i], es[i], ec[i]);
      end
    end
    n_checks++;
    if ({asg_step_o, busy_o, asg_rst_o, sweep_cnt_o} !== {62'd130, 1'b0, 1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL m0_done: step=%0d busy=%b asg_rst=%b cnt=%0d, want 130 0 0 1", asg_step_o, busy_o, asg_rst_o, sweep_cnt_o);
    end
  endtask

  task automatic test_mode0_clamp();
    logic [STW-1:0] es [3] = '{62'd100, 62'd115, 62'd130};
    int             ec [3] = '{0, 5, 9};
    set_cfg(2'd0, 62'd100, 62'd130, 62'd15, 32'd4, 16'd0);
    pulse_start();
    collect(100);
    n_checks++;
    if (n_pts !== 3 || done_cyc !== 13) begin
      n_fail++;
      $display("FAIL clamp_timing: pts=%0d done_cyc=%0d, want 3 13", n_pts, done_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pt_step[i] !== es[i] || pt_cyc[i] !== ec[i]) begin
        n_fail++;
        $display("FAIL clamp_point%0d: step=%0d@%0d, want %0d@%0d", i, pt_step[i], pt_cyc[i], es[i], ec[i]);
      end
    end
  endtask

  task automatic test_mode2_triangle();
    logic [STW-1:0] es [9] = '{62'd0, 62'd10, 62'd20, 62'd10, 62'd0, 62'd10, 62'd20, 62'd10, 62'd0};
    logic           ed [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_cfg(2'd2, 62'd0, 62'd20, 62'd10, 32'd1, 16'd2);
    pulse_start();
    collect(100);
    n_checks++;
    if (n_pts !== 9 || done_cyc !== 10 || sweep_cnt_o !== 16'd2) begin
      n_fail++;
      $display("FAIL tri_summary: pts=%0d done_cyc=%0d cnt=%0d, want 9 10 2", n_pts, done_cyc, sweep_cnt_o);
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (pt_step[i] !== es[i] || pt_dir[i] !== ed[i] || (i > 0 && pt_cyc[i] !== i + 1)) begin
        n_fail++;
        $display("FAIL tri_point%0d: step=%0d dir=%b cyc=%0d, want %0d %b %0d", i, pt_step[i], pt_dir[i], pt_cyc[i], es[i], ed[i], (i == 0) ? 0 : i + 1);
      end
    end
  endtask

  task automatic test_carry_clamp();
    logic [STW-1:0] top = '1;
    logic [STW-1:0] inc = '1;
    logic [STW-1:0] s0;
    inc[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s0 = (k == 0) ? 62'd1 : 62'd5;
      set_cfg(2'd0, s0, top, inc, 32'd0, 16'd0);
      pulse_start();
      collect(50);
      n_checks++;
      if (n_pts !== 2 || pt_step[0] !== s0 || pt_step[1] !== top || pt_cyc[1] !== 2 || done_cyc !== 3) begin
        n_fail++;
        $display("FAIL carry_%0d: pts=%0d p0=%0d p1=%h@%0d done_cyc=%0d, want 2 %0d %h@2 3", k, n_pts, pt_step[0], pt_step[1], pt_cyc[1], done_cyc, s0, top);
      end
    end
  endtask

  task automatic test_stop_and_rearm();
    logic [STW-1:0] es [5] = '{62'd10, 62'd20, 62'd0, 62'd10, 62'd20};
    int             ec [5] = '{4, 7, 10, 13, 16};
    int             stray;
    set_cfg(2'd1, 62'd0, 62'd20, 62'd10, 32'd3, 16'd0);
    pulse_start();
    for (int i = 0; i < 16; i++) begin pt_step[i] = '1; pt_cyc[i] = -1; end
    n_pts = 0;
    for (int c = 1; c <= 18; c++) begin
      if (c == 2) begin cfg_step_start_i = 62'd5; cfg_start_i = 1'b1; end
      tick();
      cfg_start_i = 1'b0;
      cyc = c;
      if (asg_step_vld_o) record();
    end
    n_checks++;
    if (n_pts !== 5 || sweep_cnt_o !== 16'd1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL saw_summary: pts=%0d cnt=%0d busy=%b, want 5 1 1", n_pts, sweep_cnt_o, busy_o);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (pt_step[i] !== es[i] || pt_cyc[i] !== ec[i]) begin
        n_fail++;
        $display("FAIL saw_point%0d: step=%0d@%0d, want %0d@%0d", i, pt_step[i], pt_cyc[i], es[i], ec[i]);
      end
    end
    cfg_stop_i = 1'b1;
    tick();
    cfg_stop_i = 1'b0;
    n_checks++;
    if ({asg_step_vld_o, busy_o, done_o, asg_rst_o, asg_step_o} !== {4'b0001, 62'd20}) begin
      n_fail++;
      $display("FAIL stop_at_expiry: vld=%b busy=%b done=%b asg_rst=%b step=%0d, want 0 0 0 1 20", asg_step_vld_o, busy_o, done_o, asg_rst_o, asg_step_o);
    end
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (asg_step_vld_o || asg_trig_o || busy_o) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL stop_quiet: activity=%0d, want 0", stray);
    end
    set_cfg(2'd0, 62'd7, 62'd7, 62'd1, 32'd2, 16'd0);
    pulse_start();
    n_checks++;
    if ({asg_step_vld_o, busy_o, asg_rst_o, asg_step_o, sweep_cnt_o} !== {3'b110, 62'd7, 16'd0}) begin
      n_fail++;
      $display("FAIL rearm: vld=%b busy=%b asg_rst=%b step=%0d cnt=%0d, want 1 1 0 7 0", asg_step_vld_o, busy_o, asg_rst_o, asg_step_o, sweep_cnt_o);
    end
    collect(50);
    n_checks++;
    if (n_pts !== 1 || done_cyc !== 3 || sweep_cnt_o !== 16'd1) begin
      n_fail++;
      $display("FAIL rearm_done: pts=%0d done_cyc=%0d cnt=%0d, want 1 3 1", n_pts, done_cyc, sweep_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    set_cfg(2'd1, 62'd3, 62'd30, 62'd4, 32'd3, 16'd0);
    pulse_start();
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({asg_step_o, asg_step_vld_o, asg_trig_o, asg_rst_o, busy_o, done_o, dir_o, sweep_cnt_o, err_o}
        !== {{STW{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: step=%0d vld=%b rst=%b busy=%b done=%b cnt=%0d", asg_step_o, asg_step_vld_o, asg_rst_o, busy_o, done_o, sweep_cnt_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_reject();
    test_start_stop_same();
    test_mode0_basic();
    test_mode0_clamp();
    test_mode2_triangle();
    test_carry_clamp();
    test_stop_and_rearm();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
